iq_issue_ctrl: RTL and testbench

Issue controller for the decoded-instruction queue in the MIPS superscalar core. Generates the queue's write and read strobes, mirrors its occupancy to stall decode, and issues the head entry to the execution stage only when a 32-entry register scoreboard shows no RAW or WAW hazard. It serialises jr/jal, and after a redirect it drains wrong-path queue entries by popping them without issue.

---
 rtl/iq_issue_ctrl_pkg.sv | 16 +
 rtl/iqc_scoreboard.sv | 53 +++++
 rtl/iq_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_iq_issue_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_issue_ctrl_pkg.sv
// Shared types and constants for the instruction-queue issue controller.
// Holds the state encoding, link register and default queue/register widths.
package iq_issue_ctrl_pkg;

  localparam int IQC_DEPTH  = 2;
  localparam int IQC_AWIDTH = 5;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    IQC_RUN   = 2'd0,
    IQC_HOLD  = 2'd1,
    IQC_FLUSH = 2'd2
  } iqc_state_e;

endpackage

// File: rtl/iqc_scoreboard.sv
// Register busy vector: set on issue, clear on writeback, set wins.
// ISSUE_BYPASS_EN lets reads see a same-cycle writeback as not busy.
module iqc_scoreboard
  import iq_issue_ctrl_pkg::*;
#(
  parameter int AW = IQC_AWIDTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          set_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  input  logic [AW-1:0] dst_addr_i,
  output logic          rs_busy_o,
  output logic          rt_busy_o,
  output logic          dst_busy_o
);

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] view;

  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

`ifdef ISSUE_BYPASS_EN
  always_comb begin
    view = busy_q;
    if (clr_i) view[clr_addr_i] = 1'b0;
  end
`else
  assign view = busy_q;
`endif

  assign rs_busy_o  = view[rs_addr_i];
  assign rt_busy_o  = view[rt_addr_i];
  assign dst_busy_o = view[dst_addr_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

endmodule

// File: rtl/iq_issue_ctrl.sv
// Issue controller for the decoded-instruction queue (RUN/HOLD/FLUSH).
// Optional ISSUE_BYPASS_EN: hazard check reads through same-cycle writeback.
module iq_issue_ctrl
  import iq_issue_ctrl_pkg::*;
#(
  parameter int DEPTH  = IQC_DEPTH,
  parameter int AWIDTH = IQC_AWIDTH
) (
  input  logic              qc_clk,
  input  logic              qc_rst,
  input  logic              dec_i_valid,
  output logic              dec_o_stall,
  output logic              q_o_we,
  output logic              q_o_re,
  input  logic [AWIDTH-1:0] q_i_addr_rs,
  input  logic [AWIDTH-1:0] q_i_addr_rt,
  input  logic [AWIDTH-1:0] q_i_addr_rd,
  input  logic              q_i_reg_dst,
  input  logic              q_i_alu_src,
  input  logic              q_i_memwrite,
  input  logic              q_i_regwrite,
  input  logic              q_i_jr,
  input  logic              q_i_jal,
  input  logic              ex_i_ready,
  output logic              ex_o_issue,
  input  logic              wb_i_valid,
  input  logic [AWIDTH-1:0] wb_i_addr,
  input  logic              redirect_i
);

  localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(2 ** DEPTH);
  localparam logic [DEPTH:0] ONE_CNT  = (DEPTH+1)'(1);

  iqc_state_e st_q, st_d;
  logic [DEPTH:0] cnt_q, cnt_d;

  logic full, empty;
  logic [AWIDTH-1:0] dst;
  logic dst_vld, rt_src, hazard, can_issue;
  logic rs_busy, rt_busy, dst_busy;
  logic we, re, iss, stall;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  assign dst = q_i_jal     ? AWIDTH'(REG_RA) :
               q_i_reg_dst ? q_i_addr_rd : q_i_addr_rt;

  assign dst_vld = (q_i_regwrite | q_i_jal) & (dst != '0);
  assign rt_src  = ~q_i_alu_src | q_i_memwrite;

  assign hazard = rs_busy
                | (rt_src & rt_busy)
                | (dst_vld & dst_busy);

  assign can_issue = ~empty & ex_i_ready & ~hazard;

  always_comb begin
    st_d  = st_q;
    we    = 1'b0;
    re    = 1'b0;
    iss   = 1'b0;
    stall = full;
    unique case (st_q)
      IQC_RUN: begin
        we  = dec_i_valid & ~full;
        iss = can_issue;
        re  = can_issue;
        if (can_issue & (q_i_jr | q_i_jal))
          st_d = IQC_HOLD;
      end
      IQC_HOLD: begin
        if (redirect_i) begin
          stall = 1'b1;
          st_d  = IQC_FLUSH;
        end else begin
          we = dec_i_valid & ~full;
        end
      end
      IQC_FLUSH: begin
        stall = 1'b1;
        re    = ~empty;
        // pop drains the last entry (or none left): back to RUN
        if (cnt_q <= ONE_CNT) st_d = IQC_RUN;
      end
      default: st_d = IQC_RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({we, re})
      2'b10:   cnt_d = cnt_q + ONE_CNT;
      2'b01:   cnt_d = cnt_q - ONE_CNT;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge qc_clk or negedge qc_rst) begin
    if (!qc_rst) begin
      st_q  <= IQC_RUN;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // strobes forced quiet while reset is held
  assign q_o_we      = qc_rst & we;
  assign q_o_re      = qc_rst & re;
  assign ex_o_issue  = qc_rst & iss;
  assign dec_o_stall = ~qc_rst | stall;

  iqc_scoreboard #(
    .AW(AWIDTH)
  ) u_sb (
    .clk_i      (qc_clk),
    .rst_ni     (qc_rst),
    .set_i      (iss & dst_vld),
    .set_addr_i (dst),
    .clr_i      (wb_i_valid),
    .clr_addr_i (wb_i_addr),
    .rs_addr_i  (q_i_addr_rs),
    .rt_addr_i  (q_i_addr_rt),
    .dst_addr_i (dst),
    .rs_busy_o  (rs_busy),
    .rt_busy_o  (rt_busy),
    .dst_busy_o (dst_busy)
  );

endmodule

// File: tb/tb_iq_issue_ctrl.sv
// Bench for iq_issue_ctrl: directed scenarios then random traffic,
// checked against a queue/scoreboard model of the issue rules.
module tb_iq_issue_ctrl;

  logic       qc_clk;
  logic       qc_rst;
  logic       dec_i_valid;
  logic       dec_o_stall;
  logic       q_o_we;
  logic       q_o_re;
  logic [4:0] q_i_addr_rs;
  logic [4:0] q_i_addr_rt;
  logic [4:0] q_i_addr_rd;
  logic       q_i_reg_dst;
  logic       q_i_alu_src;
  logic       q_i_memwrite;
  logic       q_i_regwrite;
  logic       q_i_jr;
  logic       q_i_jal;
  logic       ex_i_ready;
  logic       ex_o_issue;
  logic       wb_i_valid;
  logic [4:0] wb_i_addr;
  logic       redirect_i;

  iq_issue_ctrl dut (
    .qc_clk       (qc_clk),
    .qc_rst       (qc_rst),
    .dec_i_valid  (dec_i_valid),
    .dec_o_stall  (dec_o_stall),
    .q_o_we       (q_o_we),
    .q_o_re       (q_o_re),
    .q_i_addr_rs  (q_i_addr_rs),
    .q_i_addr_rt  (q_i_addr_rt),
    .q_i_addr_rd  (q_i_addr_rd),
    .q_i_reg_dst  (q_i_reg_dst),
    .q_i_alu_src  (q_i_alu_src),
    .q_i_memwrite (q_i_memwrite),
    .q_i_regwrite (q_i_regwrite),
    .q_i_jr       (q_i_jr),
    .q_i_jal      (q_i_jal),
    .ex_i_ready   (ex_i_ready),
    .ex_o_issue   (ex_o_issue),
    .wb_i_valid   (wb_i_valid),
    .wb_i_addr    (wb_i_addr),
    .redirect_i   (redirect_i)
  );

  initial qc_clk = 1'b0;
  always #5 qc_clk = ~qc_clk;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic reg_dst, alu_src, memwrite;
    logic regwrite, jr, jal;
  } ent_t;

  localparam int QCAP = 4;

  ent_t q[$];
  ent_t nxt;
  ent_t hd;
  bit   busy [32];
  bit   holding;
  bit   flushing;
  bit   e_we, e_re, e_iss, e_stall;
  int   nchk;
  int   npass;

  function automatic ent_t mk(
    int rs, int rt, int rd,
    bit rdst, bit asrc, bit mw,
    bit rw, bit jr, bit jal);
    ent_t e;
    e.rs = 5'(rs);
    e.rt = 5'(rt);
    e.rd = 5'(rd);
    e.reg_dst = rdst;
    e.alu_src = asrc;
    e.memwrite = mw;
    e.regwrite = rw;
    e.jr = jr;
    e.jal = jal;
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.rs = 5'($urandom_range(0, 7));
    e.rt = 5'($urandom_range(0, 7));
    e.rd = 5'($urandom_range(0, 7));
    e.reg_dst = 1'($urandom_range(0, 1));
    e.alu_src = 1'($urandom_range(0, 1));
    e.memwrite = 1'($urandom_range(0, 1));
    e.regwrite = 1'($urandom_range(0, 1));
    e.jal = ($urandom_range(0, 11) == 0);
    e.jr = !e.jal && ($urandom_range(0, 11) == 0);
    return e;
  endfunction

  function automatic bit busy_now(logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef ISSUE_BYPASS_EN
    if (wb_i_valid && wb_i_addr == r) return 1'b0;
`endif
    return busy[r];
  endfunction

  function automatic logic [4:0] dst_of(ent_t e);
    if (e.jal) return 5'd31;
    return e.reg_dst ? e.rd : e.rt;
  endfunction

  function automatic bit dst_ok(ent_t e);
    return (e.regwrite || e.jal) && dst_of(e) != 5'd0;
  endfunction

  function automatic bit blocked(ent_t e);
    bit rt_used;
    rt_used = !e.alu_src || e.memwrite;
    return busy_now(e.rs)
        || (rt_used && busy_now(e.rt))
        || (dst_ok(e) && busy_now(dst_of(e)));
  endfunction

  task automatic check(string tag, logic obs, logic exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    foreach (busy[i]) busy[i] = 1'b0;
    holding = 1'b0;
    flushing = 1'b0;
  endtask

  task automatic step(
    input bit dv, input bit rdy,
    input bit wbv, input logic [4:0] wba,
    input bit rd);
    bit full;
    if (q.size() > 0) hd = q[0];
    else hd = rand_ent();
    dec_i_valid = dv;
    ex_i_ready = rdy;
    wb_i_valid = wbv;
    wb_i_addr = wba;
    redirect_i = rd;
    q_i_addr_rs = hd.rs;
    q_i_addr_rt = hd.rt;
    q_i_addr_rd = hd.rd;
    q_i_reg_dst = hd.reg_dst;
    q_i_alu_src = hd.alu_src;
    q_i_memwrite = hd.memwrite;
    q_i_regwrite = hd.regwrite;
    q_i_jr = hd.jr;
    q_i_jal = hd.jal;
    #2;
    full = (q.size() == QCAP);
    e_we = 1'b0;
    e_re = 1'b0;
    e_iss = 1'b0;
    e_stall = full;
    if (flushing) begin
      e_stall = 1'b1;
      e_re = (q.size() > 0);
    end else if (holding) begin
      if (rd) e_stall = 1'b1;
      else e_we = dv && !full;
    end else begin
      e_we = dv && !full;
      e_iss = (q.size() > 0) && rdy && !blocked(hd);
      e_re = e_iss;
    end
    check("we", q_o_we, e_we);
    check("re", q_o_re, e_re);
    check("issue", ex_o_issue, e_iss);
    check("stall", dec_o_stall, e_stall);
    @(posedge qc_clk);
    #1;
    if (wbv) busy[wba] = 1'b0;
    if (e_iss && dst_ok(hd)) busy[dst_of(hd)] = 1'b1;
    if (e_re) q.delete(0);
    if (e_we) q.push_back(nxt);
    if (flushing) begin
      if (q.size() == 0) flushing = 1'b0;
    end else if (holding) begin
      if (rd) begin
        holding = 1'b0;
        flushing = 1'b1;
      end
    end else if (e_iss && (hd.jr || hd.jal)) begin
      holding = 1'b1;
    end
  endtask

  task automatic reset_checks(string tag);
    check({tag, "_we"}, q_o_we, 1'b0);
    check({tag, "_re"}, q_o_re, 1'b0);
    check({tag, "_iss"}, ex_o_issue, 1'b0);
    check({tag, "_stall"}, dec_o_stall, 1'b1);
  endtask

  ent_t plain;
  ent_t jal_e;

  initial begin
    nchk = 0;
    npass = 0;
    model_reset();
    plain = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    jal_e = mk(0, 0, 0, 0, 1, 0, 0, 0, 1);
    qc_rst = 1'b0;
    dec_i_valid = 1'b1;
    ex_i_ready = 1'b1;
    wb_i_valid = 1'b0;
    wb_i_addr = 5'd0;
    redirect_i = 1'b0;
    q_i_addr_rs = 5'd0;
    q_i_addr_rt = 5'd0;
    q_i_addr_rd = 5'd0;
    q_i_reg_dst = 1'b0;
    q_i_alu_src = 1'b1;
    q_i_memwrite = 1'b0;
    q_i_regwrite = 1'b0;
    q_i_jr = 1'b0;
    q_i_jal = 1'b0;
    #3;
    reset_checks("rst");
    @(posedge qc_clk);
    #1;
    qc_rst = 1'b1;

    // fill: 4 writes, stall from the 5th cycle
    nxt = plain;
    repeat (5) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);

    // RAW on $3
    nxt = mk(1, 2, 3, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    nxt = mk(3, 2, 4, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 3, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 4, 0);

    // rt-only target: WAW stall, then rt busy but not a source
    nxt = mk(0, 5, 0, 0, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 5, 0);
    step(0, 1, 0, 0, 0);
    nxt = mk(0, 5, 6, 1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 5, 0);
    step(0, 1, 1, 6, 0);

    // jal: hold, redirect collides with a decode write, flush 3
    nxt = jal_e;
    step(1, 0, 0, 0, 0);
    nxt = plain;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    repeat (4) step(0, 1, 0, 0, 0);
    nxt = mk(31, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 31, 0);
    step(0, 1, 0, 0, 0);

    // reset while flushing two entries
    nxt = jal_e;
    step(1, 0, 0, 0, 0);
    nxt = plain;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    check("flush_re", q_o_re, 1'b1);
    #1;
    qc_rst = 1'b0;
    #1;
    reset_checks("midrst");
    model_reset();
    @(posedge qc_clk);
    #1;
    qc_rst = 1'b1;
    nxt = mk(31, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int bl[$];
      bit wbv;
      bit rd;
      logic [4:0] wba;
      wbv = 1'b0;
      wba = 5'd0;
      for (int r = 1; r < 32; r++)
        if (busy[r]) bl.push_back(r);
      if (bl.size() > 0 && $urandom_range(0, 9) < 4) begin
        wbv = 1'b1;
        wba = 5'(bl[$urandom_range(0, bl.size() - 1)]);
      end
      if (holding) rd = ($urandom_range(0, 2) == 0);
      else rd = ($urandom_range(0, 9) == 0);
      nxt = rand_ent();
      step(
        $urandom_range(0, 9) < 6,
        $urandom_range(0, 9) < 7,
        wbv, wba, rd);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
